// File: rtl/dual_slope_pkg.sv
// Shared types for the dual-slope conversion sequencer.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package dual_slope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REF = 3'd1,
        ST_DEAD     = 3'd2,
        ST_AZ       = 3'd3,
        ST_INT      = 3'd4,
        ST_DEINT    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Bit positions inside the integrator switch vector.
    localparam int SW_AZ      = 0;
    localparam int SW_IN      = 1;
    localparam int SW_REF_POS = 2;
    localparam int SW_REF_NEG = 3;
    localparam int SW_W       = 4;

    // Switch pattern for a state. Only one bit can ever be set, so the
    // integrator network never sees two sources at once.
    function automatic logic [SW_W-1:0] sw_decode(input state_t st, input logic pol);
        logic [SW_W-1:0] v;
        v = '0;
        case (st)
            ST_AZ:    v[SW_AZ] = 1'b1;
            ST_INT:   v[SW_IN] = 1'b1;
            // Positive input charged the integrator up, so discharge with -Vref.
            ST_DEINT: if (pol) v[SW_REF_NEG] = 1'b1; else v[SW_REF_POS] = 1'b1;
            default:  ;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// Loadable down-counter timing every fixed-length sequencer phase; o_zero marks the last cycle.
// Latency: load takes effect next cycle; a load of N-1 gives an N-cycle phase.
// Backpressure: none; decrements whenever enabled, parks at zero.
// Ports: i_clk/i_rst_n clock and async reset, i_load/i_load_val load, i_en count enable, o_zero terminal flag.
module seq_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dual_slope_sequencer.sv
// Dual-slope ADC controller: auto-zero, fixed integrate, reference de-integrate, signed-magnitude result.
// Latency: 1 + T_DEAD + T_AZ + T_DEAD + T_INT + T_DEAD + count cycles from start to valid_o.
// Backpressure: result/flags held in DONE until valid_o & ready_i; start_i ignored until then.
// Ports: clk_i/rst_n_i; start_i/abort_i control; comp_i/sat_hi_i/sat_lo_i/ref_ok_i status;
//        sw_*_o integrator switches; busy_o; result_o/polarity_o/ovr_o/err_o with valid_o/ready_i.
module dual_slope_sequencer #(
    parameter int CNT_W       = 16,
    parameter int T_AZ        = 1024,
    parameter int T_INT       = 10000,
    parameter int T_DEINT_MAX = 20000,
    parameter int T_REF_TO    = 4096,
    parameter int T_DEAD      = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             comp_i,
    input  logic             sat_hi_i,
    input  logic             sat_lo_i,
    input  logic             ref_ok_i,
    output logic             sw_az_o,
    output logic             sw_in_o,
    output logic             sw_ref_pos_o,
    output logic             sw_ref_neg_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] result_o,
    output logic             polarity_o,
    output logic             ovr_o,
    output logic             err_o,
    output logic             valid_o,
    input  logic             ready_i
);
    import dual_slope_pkg::*;

    // Timer loads are length-1 so that the zero flag lands on the last cycle.
    localparam logic [CNT_W-1:0] L_AZ     = CNT_W'(T_AZ - 1);
    localparam logic [CNT_W-1:0] L_INT    = CNT_W'(T_INT - 1);
    localparam logic [CNT_W-1:0] L_REF_TO = CNT_W'(T_REF_TO - 1);
    localparam logic [CNT_W-1:0] L_DEAD   = CNT_W'(T_DEAD - 1);
    localparam logic [CNT_W-1:0] L_DMAX   = CNT_W'(T_DEINT_MAX);

    state_t           r_state, w_state_nxt;
    state_t           r_tgt, w_tgt_nxt;      // phase entered once the dead gap expires
    logic [SW_W-1:0]  r_sw;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [CNT_W-1:0] r_result, w_result_nxt;
    logic             r_polarity, w_pol_nxt;
    logic             r_ovr, w_ovr_nxt;
    logic             r_err, w_err_nxt;
    logic             w_ld;
    logic [CNT_W-1:0] w_ld_val;
    logic             w_tmr_zero;
    logic             w_busy;
    logic             w_ref_watch;
    logic             w_sat_watch;

    assign w_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);

    seq_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk      (clk_i),
        .i_rst_n    (rst_n_i),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_en       (w_busy),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_tgt_nxt    = r_tgt;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_pol_nxt    = r_polarity;
        w_ovr_nxt    = r_ovr;
        w_err_nxt    = r_err;
        w_ld         = 1'b0;
        w_ld_val     = '0;
        w_cnt_inc    = r_cnt + CNT_W'(1);
        w_ref_watch  = (r_state == ST_DEAD) || (r_state == ST_AZ) ||
                       (r_state == ST_INT)  || (r_state == ST_DEINT);
        w_sat_watch  = (r_state == ST_INT)  || (r_state == ST_DEINT);

        // Priority: abort, reference loss, saturation, then normal sequencing.
        if (abort_i && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end else if (w_ref_watch && !ref_ok_i) begin
            w_state_nxt  = ST_DONE;
            w_err_nxt    = 1'b1;
            w_result_nxt = '0;
        end else if (w_sat_watch && (sat_hi_i || sat_lo_i)) begin
            w_state_nxt  = ST_DONE;
            w_ovr_nxt    = 1'b1;
            w_result_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i && !valid_o) begin
                        w_state_nxt  = ST_WAIT_REF;
                        w_ld         = 1'b1;
                        w_ld_val     = L_REF_TO;
                        w_result_nxt = '0;
                        w_pol_nxt    = 1'b0;
                        w_ovr_nxt    = 1'b0;
                        w_err_nxt    = 1'b0;
                    end
                end
                ST_WAIT_REF: begin
                    if (ref_ok_i) begin
                        w_state_nxt = ST_DEAD;
                        w_tgt_nxt   = ST_AZ;
                        w_ld        = 1'b1;
                        w_ld_val    = L_DEAD;
                    end else if (w_tmr_zero) begin
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (w_tmr_zero) begin
                        w_state_nxt = r_tgt;
                        w_ld        = 1'b1;
                        w_ld_val    = (r_tgt == ST_AZ) ? L_AZ : L_INT;
                    end
                end
                ST_AZ: begin
                    if (w_tmr_zero) begin
                        w_state_nxt = ST_DEAD;
                        w_tgt_nxt   = ST_INT;
                        w_ld        = 1'b1;
                        w_ld_val    = L_DEAD;
                    end
                end
                ST_INT: begin
                    if (w_tmr_zero) begin
                        w_pol_nxt   = comp_i;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DEAD;
                        w_tgt_nxt   = ST_DEINT;
                        w_ld        = 1'b1;
                        w_ld_val    = L_DEAD;
                    end
                end
                ST_DEINT: begin
                    // Crossing is tested first so it wins over the limit.
                    if (comp_i != r_polarity) begin
                        w_state_nxt  = ST_DONE;
                        w_result_nxt = r_cnt;
                    end else if (w_cnt_inc == L_DMAX) begin
                        w_state_nxt  = ST_DONE;
                        w_result_nxt = L_DMAX;
                        w_ovr_nxt    = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    if (ready_i) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_tgt      <= ST_AZ;
            r_sw       <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_polarity <= 1'b0;
            r_ovr      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tgt      <= w_tgt_nxt;
            // Decoding from the next state keeps switches aligned with the state register.
            r_sw       <= sw_decode(w_state_nxt, w_pol_nxt);
            r_cnt      <= w_cnt_nxt;
            r_result   <= w_result_nxt;
            r_polarity <= w_pol_nxt;
            r_ovr      <= w_ovr_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign sw_az_o      = r_sw[SW_AZ];
    assign sw_in_o      = r_sw[SW_IN];
    assign sw_ref_pos_o = r_sw[SW_REF_POS];
    assign sw_ref_neg_o = r_sw[SW_REF_NEG];
    assign busy_o       = w_busy;
    assign valid_o      = (r_state == ST_DONE);
    assign result_o     = r_result;
    assign polarity_o   = r_polarity;
    assign ovr_o        = r_ovr;
    assign err_o        = r_err;

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// Scoreboard bench for dual_slope_sequencer with shortened phase lengths.
// Latency: n/a.
// Backpressure: ready_i held low for a few cycles on selected results.
module tb_dual_slope_sequencer;

    localparam int CNT_W       = 16;
    localparam int T_AZ        = 8;
    localparam int T_INT       = 16;
    localparam int T_DEINT_MAX = 40;
    localparam int T_REF_TO    = 10;
    localparam int T_DEAD      = 2;

    logic             clk_i = 1'b0;
    logic             rst_n_i, start_i, abort_i, comp_i, sat_hi_i, sat_lo_i, ref_ok_i, ready_i;
    logic             sw_az_o, sw_in_o, sw_ref_pos_o, sw_ref_neg_o, busy_o;
    logic [CNT_W-1:0] result_o;
    logic             polarity_o, ovr_o, err_o, valid_o;

    always #5 clk_i = ~clk_i;

    dual_slope_sequencer #(
        .CNT_W(CNT_W), .T_AZ(T_AZ), .T_INT(T_INT), .T_DEINT_MAX(T_DEINT_MAX),
        .T_REF_TO(T_REF_TO), .T_DEAD(T_DEAD)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
        .comp_i(comp_i), .sat_hi_i(sat_hi_i), .sat_lo_i(sat_lo_i), .ref_ok_i(ref_ok_i),
        .sw_az_o(sw_az_o), .sw_in_o(sw_in_o), .sw_ref_pos_o(sw_ref_pos_o),
        .sw_ref_neg_o(sw_ref_neg_o), .busy_o(busy_o), .result_o(result_o),
        .polarity_o(polarity_o), .ovr_o(ovr_o), .err_o(err_o), .valid_o(valid_o),
        .ready_i(ready_i)
    );

    typedef struct {
        logic [CNT_W-1:0] result;
        logic             pol;
        logic             ovr;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({sw_az_o, sw_in_o, sw_ref_pos_o, sw_ref_neg_o, busy_o,
                    polarity_o, ovr_o, err_o, valid_o, result_o});
    endfunction

    function automatic logic [3:0] sw_vec();
        return {sw_ref_neg_o, sw_ref_pos_o, sw_in_o, sw_az_o};
    endfunction

    // Switch monitor: one-hot check every cycle plus run lengths of each phase and dead gap.
    logic [3:0] mon_prev = 4'b0;
    int mon_run = 0;
    int az_len = 0, in_len = 0, ref_len = 0, gap_in = 0, gap_ref = 0;
    always @(negedge clk_i) begin
        logic [3:0] sw;
        sw = sw_vec();
        chk_val("sw_onehot", 32'($countones(sw) <= 1), 32'd1);
        if (sw == mon_prev) begin
            mon_run++;
        end else begin
            case (mon_prev)
                4'b0001: az_len = mon_run;
                4'b0010: in_len = mon_run;
                4'b0100, 4'b1000: ref_len = mon_run;
                4'b0000: begin
                    if (sw == 4'b0010) gap_in = mon_run;
                    else if (sw[3:2] != 2'b00) gap_ref = mon_run;
                end
                default: ;
            endcase
            mon_run = 1;
        end
        mon_prev = sw;
    end

    task automatic pulse_start();
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
    endtask

    task automatic wait_sw(input string tag, input int idx);
        int n = 0;
        logic [3:0] sw;
        do begin
            @(negedge clk_i);
            sw = sw_vec();
            n++;
        end while (!sw[idx] && n < 200);
        if (!sw[idx]) chk_val({tag, "_tmo"}, 32'd0, 32'd1);
    endtask

    // Waits for a result, compares it with the oldest expectation, optionally
    // holds ready low (pulsing start once) and then completes the handshake.
    task automatic collect(input string tag, input int hold, input bit try_start);
        exp_t e;
        int n = 0;
        while (!valid_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (!valid_o) begin
            chk_val({tag, "_valid_tmo"}, 32'd0, 32'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            chk_val({tag, "_unexpected"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk_val({tag, "_result"},   32'(result_o),   32'(e.result));
        chk_val({tag, "_polarity"}, 32'(polarity_o), 32'(e.pol));
        chk_val({tag, "_ovr"},      32'(ovr_o),      32'(e.ovr));
        chk_val({tag, "_err"},      32'(err_o),      32'(e.err));
        chk_val({tag, "_done_sw"},  32'(sw_vec()),   32'd0);
        chk_val({tag, "_done_busy"}, 32'(busy_o),    32'd0);
        for (int i = 0; i < hold; i++) begin
            start_i = try_start && (i == 0);
            @(negedge clk_i);
            chk_val({tag, "_held"},   32'(valid_o),  32'd1);
            chk_val({tag, "_stable"}, 32'(result_o), 32'(e.result));
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        chk_val({tag, "_released"}, 32'(valid_o), 32'd0);
        @(negedge clk_i);
        chk_val({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; comp_i = 1'b0;
        sat_hi_i = 1'b0; sat_lo_i = 1'b0; ref_ok_i = 1'b0; ready_i = 1'b0;
        #1;
        chk_val("reset_outs", outs_vec(), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;

        // Positive input: crossing after 20 de-integrate cycles; a stray start mid-conversion.
        ref_ok_i = 1'b1; comp_i = 1'b1;
        exp_q.push_back('{result: 16'd20, pol: 1'b1, ovr: 1'b0, err: 1'b0});
        pulse_start();
        wait_sw("t1_in", 1);
        pulse_start();
        wait_sw("t1_ref", 3);
        chk_val("t1_ref_neg", 32'(sw_ref_neg_o), 32'd1);
        repeat (20) @(negedge clk_i);
        comp_i = 1'b0;
        collect("t1", 3, 1'b0);
        chk_val("t1_az_len",  32'(az_len),  32'(T_AZ));
        chk_val("t1_in_len",  32'(in_len),  32'(T_INT));
        chk_val("t1_gap_in",  32'(gap_in),  32'(T_DEAD));
        chk_val("t1_gap_ref", 32'(gap_ref), 32'(T_DEAD));

        // Negative input: crossing after 7 cycles.
        comp_i = 1'b0;
        exp_q.push_back('{result: 16'd7, pol: 1'b0, ovr: 1'b0, err: 1'b0});
        pulse_start();
        wait_sw("t2_ref", 2);
        chk_val("t2_ref_pos", 32'(sw_ref_pos_o), 32'd1);
        repeat (7) @(negedge clk_i);
        comp_i = 1'b1;
        collect("t2", 0, 1'b0);

        // Never crosses: limit reached after exactly T_DEINT_MAX cycles.
        comp_i = 1'b1;
        exp_q.push_back('{result: 16'(T_DEINT_MAX), pol: 1'b1, ovr: 1'b1, err: 1'b0});
        pulse_start();
        wait_sw("t3_ref", 3);
        collect("t3", 0, 1'b0);
        chk_val("t3_ref_len", 32'(ref_len), 32'(T_DEINT_MAX));
        chk_val("t3_gap_in",  32'(gap_in),  32'(T_DEAD));
        chk_val("t3_gap_ref", 32'(gap_ref), 32'(T_DEAD));

        // Saturation on INT cycle 5; a start while the result is pending is ignored.
        comp_i = 1'b0;
        exp_q.push_back('{result: 16'd0, pol: 1'b0, ovr: 1'b1, err: 1'b0});
        pulse_start();
        wait_sw("t4_in", 1);
        repeat (4) @(negedge clk_i);
        sat_hi_i = 1'b1;
        @(negedge clk_i);
        sat_hi_i = 1'b0;
        chk_val("t4_sw_off", 32'(sw_vec()), 32'd0);
        chk_val("t4_valid",  32'(valid_o),  32'd1);
        collect("t4", 3, 1'b1);

        // Reference never ready: timeout after T_REF_TO busy cycles.
        ref_ok_i = 1'b0;
        exp_q.push_back('{result: 16'd0, pol: 1'b0, ovr: 1'b0, err: 1'b1});
        pulse_start();
        begin
            int nb = 0;
            int guard = 0;
            while (!valid_o && guard < 50) begin
                if (busy_o) nb++;
                @(negedge clk_i);
                guard++;
            end
            chk_val("t5_to_cycles", 32'(nb), 32'(T_REF_TO));
        end
        collect("t5", 0, 1'b0);

        // Reference lost mid auto-zero.
        ref_ok_i = 1'b1; comp_i = 1'b0;
        exp_q.push_back('{result: 16'd0, pol: 1'b0, ovr: 1'b0, err: 1'b1});
        pulse_start();
        wait_sw("t6_az", 0);
        repeat (3) @(negedge clk_i);
        ref_ok_i = 1'b0;
        @(negedge clk_i);
        chk_val("t6_sw_off", 32'(sw_vec()), 32'd0);
        chk_val("t6_err",    32'(err_o),    32'd1);
        collect("t6", 0, 1'b0);
        ref_ok_i = 1'b1;

        // Asynchronous reset during de-integrate.
        comp_i = 1'b1;
        pulse_start();
        wait_sw("t7_ref", 3);
        repeat (5) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1 chk_val("t7_rst_outs", outs_vec(), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Abort during integrate: no result ever appears.
        comp_i = 1'b0;
        pulse_start();
        wait_sw("t8_in", 1);
        repeat (3) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk_val("t8_abort_outs", 32'(outs_vec() & 32'h01FF_0000), 32'd0);
        begin
            int nv = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk_i);
                if (valid_o || busy_o) nv++;
            end
            chk_val("t8_quiet", 32'(nv), 32'd0);
        end

        chk_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
